prach_fcw_ctrl: RTL and testbench
=================================

# prach_fcw_ctrl

Configuration controller for the PRACH mixer frequency-control words. Software-side writes land in a shadow bank of 3 antennas x 8 channels of 17-bit FCWs. A commit request arms a frame-aligned transfer: the whole shadow bank is copied into the active bank on the next `sync_in` pulse. The active bank drives the mixer's `ctrl_fcw[3][8]` input, so retuning never happens mid-frame and never partially.

## Interface

Parameters:
- `NUM_ANT`, 3: antenna paths; must match the mixer.
- `NUM_CHN`, 8: channels per antenna.
- `FCW_W`, 17: FCW width.

Ports:
- `clk`  in  1  single clock for the block.
- `rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`.
- `wr_ant`  in  2  antenna index.
- `wr_chn`  in  3  channel index.
- `wr_fcw`  in  `FCW_W`  FCW value.
- `wr_err`  out  1  one-cycle pulse when an accepted write has `wr_ant >= NUM_ANT`.
- `commit`  in  1  one-cycle request to apply the shadow bank at the next sync.
- `cancel`  in  1  abandon an armed commit.
- `sync_in`  in  1  frame boundary pulse; the same sync that feeds the mixer.
- `pending`  out  1  commit armed, waiting for sync.
- `upd_done`  out  1  one-cycle pulse; the active bank changed this cycle.
- `upd_cnt`  out  8  count of applied commits; wraps 255 -> 0.
- `ctrl_fcw`  out  `FCW_W` x [`NUM_ANT`][`NUM_CHN`]  active FCWs to the mixer.

## Operation

The block has two states.

IDLE:
- `wr_ready`=1.
- An accepted write with a valid index updates `shadow[wr_ant][wr_chn]`.
- An accepted write with an invalid index is dropped and pulses `wr_err`.
- `commit`=1 moves the block to ARMED.
- `sync_in` is ignored.

ARMED:
- `wr_ready`=0, so the shadow bank is frozen between commit and apply.
- `cancel`=1 returns to IDLE. Shadow is kept and active is unchanged.
- Otherwise, `sync_in`=1 copies shadow to active (all 24 words atomically), pulses `upd_done`, increments `upd_cnt`, and returns to IDLE.
- `commit` is ignored.

Simultaneous events:
- Write and `commit` in the same IDLE cycle: the write is accepted and is included in the commit.
- `commit` and `sync_in` in the same IDLE cycle: the block arms only. Apply happens at the following sync, never the same cycle.
- `cancel` and `sync_in` in the same ARMED cycle: `cancel` wins, no apply.
- `cancel` in IDLE: no effect.

Reset (any cycle, including while ARMED):
- State IDLE, shadow and active all 0.
- `ctrl_fcw`=0, `pending`=0, `upd_done`=0, `wr_err`=0, `upd_cnt`=0, `wr_ready`=1.
- An armed commit is discarded.

`wr_chn` is 3 bits, so every value is valid for `NUM_CHN`=8. For `NUM_CHN`<8, `wr_chn >= NUM_CHN` is also an error.

## Timing

- `wr_ready` is combinational from state. It is 1 in IDLE and 0 from the cycle after `commit` until the cycle after apply or cancel.
- Shadow write: the register updates on the accepting edge. `wr_err` is registered and asserts one cycle after the bad accept.
- `pending` is registered: 1 the cycle after `commit`, 0 the cycle after apply or cancel.
- Apply: `sync_in` sampled high in ARMED at edge N. `ctrl_fcw`, `upd_done`=1 and the new `upd_cnt` are all visible after edge N (1-cycle latency). `upd_done` clears after edge N+1.
- `ctrl_fcw` is driven only from registers; there is no combinational path from any input.
- Back-to-back: a new `commit` is accepted in the first IDLE cycle after apply.

## Structure

- Package `prach_pkg` holds:
  - `NUM_ANT`, `NUM_CHN`, `FCW_W` constants;
  - `fcw_t` (logic [FCW_W-1:0]);
  - state enum `fcw_ctrl_state_e` {IDLE, ARMED}.
  The mixer shares the same package for its `ctrl_fcw` width.
- Sub-module `prach_fcw_bank`: the shadow and active register arrays. It has a write port, an apply strobe and a synchronous reset. `prach_fcw_ctrl` keeps the FSM, the index check and the counter.

## Test plan

- Reset then idle 100 cycles with random `sync_in` -> `ctrl_fcw` all 0, `upd_cnt`=0, `wr_ready`=1, `pending`=0.
- Write ant1/chn5=0x1ABCD, commit, `sync_in` 10 cycles later -> `pending` high for 10 cycles. Then `ctrl_fcw[1][5]`=0x1ABCD, `upd_done` for one cycle, `upd_cnt`=1; all other words remain 0.
- Write ant3/chn0 -> `wr_err` pulses once, and no `ctrl_fcw` word changes after the next commit plus sync.
- Commit, then write attempt while ARMED -> `wr_ready`=0 and the write is not taken. `cancel` together with `sync_in` -> no apply, `upd_cnt` unchanged, IDLE.
- `commit` coincident with `sync_in` -> no apply that cycle. Apply occurs at the next sync only.
- 256 commit/sync cycles -> `upd_cnt` wraps to 0. Assert `rst` mid-ARMED -> all outputs at reset values, and the next sync does not apply.

Source files
------------

// File: rtl/prach_pkg.sv
// Shared constants and types for the PRACH mixer and its FCW configuration controller.
package prach_pkg;

    localparam int unsigned NUM_ANT = 3;
    localparam int unsigned NUM_CHN = 8;
    localparam int unsigned FCW_W   = 17;

    typedef logic [FCW_W-1:0] fcw_t;

    typedef enum logic {
        IDLE,
        ARMED
    } fcw_ctrl_state_e;

endpackage

// File: rtl/prach_fcw_bank.sv
// Shadow and active FCW register arrays; apply copies the whole shadow bank in one edge.
module prach_fcw_bank #(
    parameter int unsigned NUM_ANT = prach_pkg::NUM_ANT,
    parameter int unsigned NUM_CHN = prach_pkg::NUM_CHN,
    parameter int unsigned FCW_W   = prach_pkg::FCW_W
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       wr_en,
    input  logic [1:0]                                 wr_ant,
    input  logic [2:0]                                 wr_chn,
    input  logic [FCW_W-1:0]                           wr_fcw,
    input  logic                                       apply,
    output logic [NUM_ANT-1:0][NUM_CHN-1:0][FCW_W-1:0] active
);

    logic [NUM_ANT-1:0][NUM_CHN-1:0][FCW_W-1:0] shadow_q, shadow_d;
    logic [NUM_ANT-1:0][NUM_CHN-1:0][FCW_W-1:0] active_q, active_d;

    // wr_en is only raised for in-range indices, so the dynamic select stays in bounds.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_en) begin
            shadow_d[wr_ant][wr_chn] = wr_fcw;
        end
        active_d = apply ? shadow_q : active_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;

endmodule

// File: rtl/prach_fcw_ctrl.sv
// Frame-aligned FCW configuration controller: writes fill a shadow bank, a commit
// arms a transfer, and the next sync copies the whole bank to the mixer-facing copy.
module prach_fcw_ctrl #(
    parameter int unsigned NUM_ANT = prach_pkg::NUM_ANT,
    parameter int unsigned NUM_CHN = prach_pkg::NUM_CHN,
    parameter int unsigned FCW_W   = prach_pkg::FCW_W
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       wr_valid,
    output logic                                       wr_ready,
    input  logic [1:0]                                 wr_ant,
    input  logic [2:0]                                 wr_chn,
    input  logic [FCW_W-1:0]                           wr_fcw,
    output logic                                       wr_err,
    input  logic                                       commit,
    input  logic                                       cancel,
    input  logic                                       sync_in,
    output logic                                       pending,
    output logic                                       upd_done,
    output logic [7:0]                                 upd_cnt,
    output logic [NUM_ANT-1:0][NUM_CHN-1:0][FCW_W-1:0] ctrl_fcw
);

    import prach_pkg::*;

    fcw_ctrl_state_e state_q, state_d;
    logic            pending_q, pending_d;
    logic            upd_done_q, upd_done_d;
    logic            wr_err_q, wr_err_d;
    logic [7:0]      upd_cnt_q, upd_cnt_d;

    logic wr_accept;
    logic wr_bad;
    logic apply;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            upd_done_q <= 1'b0;
            wr_err_q   <= 1'b0;
            upd_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            upd_done_q <= upd_done_d;
            wr_err_q   <= wr_err_d;
            upd_cnt_q  <= upd_cnt_d;
        end
    end

    // Next-state logic; cancel outranks a coincident sync
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (commit) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (cancel || sync_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath controls
    always_comb begin
        wr_ready   = (state_q == IDLE);
        wr_accept  = wr_valid && wr_ready;
        wr_bad     = (32'(wr_ant) >= NUM_ANT) || (32'(wr_chn) >= NUM_CHN);
        apply      = (state_q == ARMED) && !cancel && sync_in;
        wr_err_d   = wr_accept && wr_bad;
        upd_done_d = apply;
        upd_cnt_d  = apply ? upd_cnt_q + 8'd1 : upd_cnt_q;
        pending_d  = (state_d == ARMED);
    end

    prach_fcw_bank #(
        .NUM_ANT (NUM_ANT),
        .NUM_CHN (NUM_CHN),
        .FCW_W   (FCW_W)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_accept && !wr_bad),
        .wr_ant (wr_ant),
        .wr_chn (wr_chn),
        .wr_fcw (wr_fcw),
        .apply  (apply),
        .active (ctrl_fcw)
    );

    assign pending  = pending_q;
    assign upd_done = upd_done_q;
    assign wr_err   = wr_err_q;
    assign upd_cnt  = upd_cnt_q;

endmodule

// File: tb/tb_prach_fcw_ctrl.sv
// Scoreboard bench for prach_fcw_ctrl: a behavioural model predicts applies and write
// errors into queues, and a monitor pops and compares them when the DUT pulses.
module tb_prach_fcw_ctrl;

    localparam int NA = 3;
    localparam int NC = 8;
    localparam int FW = 17;

    typedef logic [NA-1:0][NC-1:0][FW-1:0] bank_t;
    typedef struct {
        bank_t      bank;
        logic [7:0] cnt;
    } upd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [1:0]    wr_ant = '0;
    logic [2:0]    wr_chn = '0;
    logic [FW-1:0] wr_fcw = '0;
    logic          wr_err;
    logic          commit = 1'b0;
    logic          cancel = 1'b0;
    logic          sync_in = 1'b0;
    logic          pending;
    logic          upd_done;
    logic [7:0]    upd_cnt;
    bank_t         ctrl_fcw;

    prach_fcw_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_ant   (wr_ant),
        .wr_chn   (wr_chn),
        .wr_fcw   (wr_fcw),
        .wr_err   (wr_err),
        .commit   (commit),
        .cancel   (cancel),
        .sync_in  (sync_in),
        .pending  (pending),
        .upd_done (upd_done),
        .upd_cnt  (upd_cnt),
        .ctrl_fcw (ctrl_fcw)
    );

    always #5 clk = ~clk;

    // Reference model state
    int         shadow [NA][NC];
    bank_t      mod_active;
    bit         mod_armed;
    int         mod_cnt;
    upd_t       upd_q [$];
    int         err_q [$];
    bit         mon_en = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [NA*NC*FW-1:0] act, logic [NA*NC*FW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int a = 0; a < NA; a++)
            for (int c = 0; c < NC; c++)
                shadow[a][c] = 0;
        mod_active = '0;
        mod_armed  = 1'b0;
        mod_cnt    = 0;
        upd_q.delete();
        err_q.delete();
    endfunction

    // One clock: drive inputs, advance the model, wait for the next falling edge.
    task automatic cycle(input bit v, input int ant, input int chn, input int fcw,
                         input bit com, input bit can, input bit syn, input bit r);
        upd_t u;
        wr_valid = v;
        wr_ant   = 2'(ant);
        wr_chn   = 3'(chn);
        wr_fcw   = FW'(fcw);
        commit   = com;
        cancel   = can;
        sync_in  = syn;
        rst      = r;
        if (r) begin
            model_reset();
        end else if (!mod_armed) begin
            if (v) begin
                if (ant < NA && chn < NC) shadow[ant][chn] = fcw % (1 << FW);
                else err_q.push_back(1);
            end
            if (com) mod_armed = 1'b1;
        end else if (can) begin
            mod_armed = 1'b0;
        end else if (syn) begin
            for (int a = 0; a < NA; a++)
                for (int c = 0; c < NC; c++)
                    mod_active[a][c] = FW'(shadow[a][c]);
            mod_cnt   = (mod_cnt + 1) % 256;
            mod_armed = 1'b0;
            u.bank = mod_active;
            u.cnt  = 8'(mod_cnt);
            upd_q.push_back(u);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rnd_sync);
        for (int i = 0; i < n; i++)
            cycle(0, 0, 0, 0, 0, 0, rnd_sync ? bit'($urandom_range(0, 1)) : 1'b0, 0);
    endtask

    // Monitor: sample shortly after each rising edge
    always @(posedge clk) begin
        upd_t u;
        #2;
        if (mon_en) begin
            chk("wr_ready", wr_ready, !mod_armed);
            chk("pending", pending, mod_armed);
            chk("ctrl_fcw", ctrl_fcw, mod_active);
            chk("upd_cnt", upd_cnt, mod_cnt);
            if (upd_done) begin
                if (upd_q.size() == 0) begin
                    chk("upd_done_unexpected", upd_done, 1'b0);
                end else begin
                    u = upd_q.pop_front();
                    chk("upd_bank", ctrl_fcw, u.bank);
                    chk("upd_done_cnt", upd_cnt, u.cnt);
                end
            end else if (upd_q.size() != 0) begin
                void'(upd_q.pop_front());
                chk("upd_done_missing", upd_done, 1'b1);
            end
            if (wr_err) begin
                if (err_q.size() == 0) chk("wr_err_unexpected", wr_err, 1'b0);
                else begin
                    void'(err_q.pop_front());
                    chk("wr_err", wr_err, 1'b1);
                end
            end else if (err_q.size() != 0) begin
                void'(err_q.pop_front());
                chk("wr_err_missing", wr_err, 1'b1);
            end
        end
    end

    initial begin
        @(negedge clk);
        mon_en = 1'b1;
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        idle(100, 1);

        // Single write, commit, sync ten cycles later
        cycle(1, 1, 5, 'h1ABCD, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        idle(9, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        idle(2, 0);

        // Out-of-range antenna, then commit and apply
        cycle(1, 3, 0, 'h15555, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        idle(3, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);

        // Write while armed is refused; cancel beats sync
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        cycle(1, 2, 7, 'h0F0F0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);

        // Commit coincident with write and sync: arms only
        cycle(1, 0, 3, 'h00123, 1, 0, 1, 0);
        idle(2, 0);
        cycle(0, 0, 0, 0, 1, 0, 1, 0);
        idle(1, 0);

        // 256 commit/sync rounds to wrap the counter
        for (int i = 0; i < 256; i++) begin
            cycle(1, $urandom_range(0, 2), $urandom_range(0, 7), $urandom, 1, 0, 0, 0);
            cycle(0, 0, 0, 0, 0, 0, 1, 0);
        end

        // Reset while armed discards the commit
        cycle(1, 2, 2, 'h1FFFF, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        idle(2, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 499) == 0);
        end
        idle(3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
